// File: rtl/operand_forward_ctrl.sv
// ID-stage hazard/forwarding controller: registered EX operand-mux selects and load-use stall.
// Optional FWD_STATS_EN adds saturating stall/forward event counters.
module operand_forward_ctrl #(
  parameter int unsigned      REG_W    = 5,
  parameter logic [REG_W-1:0] ZERO_REG = REG_W'(31)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_imm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       ex_sel_a,
  output logic [1:0]       ex_sel_b
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      fwd_cnt
`endif
);

  localparam logic [1:0] SelRf  = 2'd0;
  localparam logic [1:0] SelEx  = 2'd1;
  localparam logic [1:0] SelMem = 2'd2;
  localparam logic [1:0] SelImm = 2'd3;

  logic [REG_W-1:0] ex_rd_q, ex_rd_d, mem_rd_q;
  logic             ex_wr_q, ex_wr_d, ex_ld_q, ex_ld_d, mem_wr_q;
  logic [1:0]       sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [1:0]       sel_a_nxt, sel_b_nxt;

  logic rn_live, rm_live;
  logic ex_hit_rn, ex_hit_rm, mem_hit_rn, mem_hit_rm;
  logic advance;

  // The zero register is never a real dependency.
  assign rn_live = id_use_rn && (id_rn != ZERO_REG);
  assign rm_live = id_use_rm && (id_rm != ZERO_REG);

  assign ex_hit_rn  = ex_wr_q  && (ex_rd_q  == id_rn) && rn_live;
  assign ex_hit_rm  = ex_wr_q  && (ex_rd_q  == id_rm) && rm_live;
  assign mem_hit_rn = mem_wr_q && (mem_rd_q == id_rn) && rn_live;
  assign mem_hit_rm = mem_wr_q && (mem_rd_q == id_rm) && rm_live;

  assign stall   = id_valid && !flush && ex_ld_q && ex_wr_q && (ex_hit_rn || ex_hit_rm);
  assign advance = id_valid && !flush && !stall;

  always_comb begin
    sel_a_nxt = SelRf;
    if (ex_hit_rn) begin
      sel_a_nxt = SelEx;
    end else if (mem_hit_rn) begin
      sel_a_nxt = SelMem;
    end

    sel_b_nxt = SelRf;
    if (id_use_imm) begin
      sel_b_nxt = SelImm;
    end else if (ex_hit_rm) begin
      sel_b_nxt = SelEx;
    end else if (mem_hit_rm) begin
      sel_b_nxt = SelMem;
    end
  end

  always_comb begin
    // Default is a bubble into EX.
    ex_rd_d = ZERO_REG;
    ex_wr_d = 1'b0;
    ex_ld_d = 1'b0;
    sel_a_d = SelRf;
    sel_b_d = SelRf;
    if (advance) begin
      ex_rd_d = id_rd;
      ex_wr_d = id_reg_write;
      ex_ld_d = id_mem_read;
      sel_a_d = sel_a_nxt;
      sel_b_d = sel_b_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd_q  <= ZERO_REG;
      ex_wr_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      mem_rd_q <= ZERO_REG;
      mem_wr_q <= 1'b0;
      sel_a_q  <= SelRf;
      sel_b_q  <= SelRf;
    end else begin
      ex_rd_q  <= ex_rd_d;
      ex_wr_q  <= ex_wr_d;
      ex_ld_q  <= ex_ld_d;
      mem_rd_q <= ex_rd_q;
      mem_wr_q <= ex_wr_q;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
    end
  end

  assign ex_sel_a = sel_a_q;
  assign ex_sel_b = sel_b_q;

`ifdef FWD_STATS_EN
  logic [15:0] stall_cnt_q, fwd_cnt_q;
  logic        fwd_event;

  // Immediate (3) and regfile (0) selects are not forwards.
  assign fwd_event = advance &&
                     ((sel_a_nxt == SelEx) || (sel_a_nxt == SelMem) ||
                      (sel_b_nxt == SelEx) || (sel_b_nxt == SelMem));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
      fwd_cnt_q   <= 16'h0000;
    end else begin
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (fwd_event && (fwd_cnt_q != 16'hFFFF)) begin
        fwd_cnt_q <= fwd_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: doc/operand_forward_ctrl.md
Name: operand_forward_ctrl

Overview:
- ID-stage hazard/forwarding controller for the pipelined CPU.
- Tracks destination registers of in-flight instructions and produces registered 2-bit selects for the EX-stage 4:1 operand muxes (A and B).
- Asserts a one-cycle load-use stall when forwarding cannot cover a hazard.
- Register file writes on the falling edge, so a writer 3 stages ahead never needs forwarding.

Parameters:
REG_W, 5, register address width
ZERO_REG, 31, hard-wired zero register; never forwarded or stalled on

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID holds a real instruction
id_rn  input  REG_W  source register A
id_rm  input  REG_W  source register B
id_use_rn  input  1  instruction reads rn
id_use_rm  input  1  instruction reads rm
id_use_imm  input  1  operand B is immediate
id_rd  input  REG_W  destination register
id_reg_write  input  1  instruction writes rd
id_mem_read  input  1  instruction is a load
flush  input  1  kill the ID instruction (branch taken)
stall  output  1  combinational; hold PC and IF/ID, insert bubble
ex_sel_a  output  2  operand A mux select, valid in EX
ex_sel_b  output  2  operand B mux select, valid in EX

Behaviour:
- Select encoding: 0 = regfile read, 1 = EX/MEM ALU result, 2 = MEM/WB result, 3 = immediate (B only; never driven on A).
- Internal slots: EX slot {ex_rd, ex_wr, ex_ld} = instruction now in EX; MEM slot {mem_rd, mem_wr} = instruction now in MEM.
- Match rule: slot matches source s when slot wr=1, slot rd==s, s!=ZERO_REG, and the corresponding use flag=1.
- stall = id_valid & !flush & ex_ld & ex_wr & (match EX slot on rn or rm).
- Next select, per operand:
  - B with id_use_imm -> 3.
  - else EX-slot match -> 1.
  - else MEM-slot match -> 2.
  - else 0.
  - EX slot (newer) has priority over MEM slot.
- Rising clk, when !stall & !flush & id_valid:
  - EX slot <= {id_rd, id_reg_write, id_mem_read}.
  - ex_sel_a/b <= next selects.
- Rising clk, when stall | flush | !id_valid:
  - Bubble: EX slot wr=0, ld=0, rd=ZERO_REG.
  - ex_sel_a = ex_sel_b = 0.
- MEM slot <= EX slot every cycle, regardless of stall.
- Stall lasts exactly one cycle:
  - After the bubble the load sits in the MEM slot and the held consumer gets sel=2.
- flush and a stall condition in the same cycle: flush wins, stall=0, bubble inserted.
- Reset (async, any time, including mid-stall):
  - All slots cleared (wr=0, ld=0, rd=ZERO_REG).
  - ex_sel_a = ex_sel_b = 0.
  - stall = 0 once reset is asserted.
  - First edge after deassertion is a normal cycle.

Optional Feature:
- Macro FWD_STATS_EN.
- Defined:
  - Adds outputs stall_cnt[15:0] and fwd_cnt[15:0], both saturating at 16'hFFFF, both cleared by rst_n.
  - stall_cnt increments on each clk edge where stall=1.
  - fwd_cnt increments by 1 on each edge loading a nonzero, non-3 select on A or B (max +1 per cycle).
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- ADD X1 then SUB X2,X1,X3 back-to-back -> SUB in EX sees ex_sel_a=1, ex_sel_b=0; stall never asserts.
- ADD X1; NOP; ORR X4,X5,X1 -> ORR in EX sees ex_sel_b=2.
- Writers to X1 in both EX and MEM slots; consumer reads X1 -> ex_sel_a=1 (newer wins).
- LDUR X7 then ADD X8,X7,X7 -> stall=1 for exactly one cycle; bubble sels 0/0; ADD in EX sees ex_sel_a=ex_sel_b=2.
- Writer to X31 followed by a reader of X31 -> sels 0, no stall.
- Immediate-B consumer of X1 -> ex_sel_b=3.
- Load-use with flush=1 in same cycle -> stall=0, bubble.
- rst_n pulsed low mid-stall -> outputs 0 immediately; no stale forward afterwards.
- With FWD_STATS_EN defined, the load-use case -> stall_cnt=1.
